// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared state and mode definitions for the configuration-stream loader
package config_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic CFG_LOAD     = 1'b0;
    localparam logic CFG_READBACK = 1'b1;

endpackage

// File: rtl/config_loader.sv
// rtl/config_loader.sv - shifts a full word stream into a configuration chain, or recirculates it for readback
module config_loader
    import config_pkg::*;
#(
    parameter int CONFIG_WIDTH = 8,
    parameter int CHAIN_WORDS  = 2,
    parameter int CNT_WIDTH    = $clog2(CHAIN_WORDS + 1)
) (
    input  logic                    config_clk,
    input  logic                    config_rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_readback,
    input  logic [CONFIG_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [CONFIG_WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    config_en,
    output logic [CONFIG_WIDTH-1:0] config_in,
    input  logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    busy,
    output logic                    done
);

    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(CHAIN_WORDS - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 beat;

    assign beat = ((state_q == LOAD) && s_valid) || ((state_q == READ) && m_ready);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cnt_d   = '0;
                    state_d = (cmd_readback == CFG_READBACK) ? READ : LOAD;
                end
            end
            LOAD, READ: begin
                if (beat) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge config_clk) begin
        if (!config_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output is forced low while reset is held, even before the reset edge lands.
    assign cmd_ready = config_rst_n && (state_q == IDLE);
    assign s_ready   = config_rst_n && (state_q == LOAD);
    assign m_valid   = config_rst_n && (state_q == READ);
    assign busy      = config_rst_n && (state_q != IDLE);
    assign done      = config_rst_n && (state_q == DONE);
    assign config_en = config_rst_n && beat;

    always_comb begin
        config_in = '0;
        m_data    = '0;
        if (config_rst_n) begin
            if (state_q == LOAD) begin
                config_in = s_data;
            end else if (state_q == READ) begin
                config_in = config_out;
                m_data    = config_out;
            end
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - bench for config_loader driving two-word and one-word chain models
module tb_config_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_readback, s_valid, s_ready;
    logic       m_valid, m_ready, config_en, busy, done;
    logic [7:0] s_data, m_data, config_in, config_out;
    logic [7:0] chain [2];

    logic       cmd_valid1, cmd_ready1, cmd_readback1, s_valid1, s_ready1;
    logic       m_valid1, m_ready1, config_en1, busy1, done1;
    logic [7:0] s_data1, m_data1, config_in1, config_out1;
    logic [7:0] chain1;

    config_loader #(.CONFIG_WIDTH(8), .CHAIN_WORDS(2)) dut (
        .config_clk(clk), .config_rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_readback(cmd_readback),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .config_en(config_en), .config_in(config_in), .config_out(config_out),
        .busy(busy), .done(done)
    );

    config_loader #(.CONFIG_WIDTH(8), .CHAIN_WORDS(1)) dut1 (
        .config_clk(clk), .config_rst_n(rst_n),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_readback(cmd_readback1),
        .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
        .config_en(config_en1), .config_in(config_in1), .config_out(config_out1),
        .busy(busy1), .done(done1)
    );

    // Chain models: index 0 is the head, the last index is the tail.
    always @(posedge clk) begin
        if (config_en) begin
            chain[0] <= config_in;
            chain[1] <= chain[0];
        end
        if (config_en1) chain1 <= config_in1;
    end
    assign config_out  = chain[1];
    assign config_out1 = chain1;

    int done_cnt = 0;
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_noise();
        logic [7:0] head, tail;
        head = chain[0];
        tail = chain[1];
        cmd_valid = 1'b0; s_valid = 1'b1; m_ready = 1'b1; s_data = 8'($urandom);
        #1 chk("idle_noise_ctl", {config_en, s_ready, m_valid, busy, cmd_ready}, 5'b00001);
        cyc();
        s_valid = 1'b0; m_ready = 1'b0;
        #1 chk("idle_noise_chain", {chain[1], chain[0]}, {tail, head});
        chk("idle_noise_still_idle", {cmd_ready, busy}, 2'b10);
    endtask

    task automatic do_load(input logic [7:0] w0, input logic [7:0] w1,
                           input int b0, input int b1, input bit noise);
        logic [7:0] w [2];
        int         bub [2];
        int         d0;
        w[0] = w0; w[1] = w1; bub[0] = b0; bub[1] = b1;
        cmd_valid = 1'b1; cmd_readback = 1'b0;
        #1 chk("load_cmd_ready", cmd_ready, 1);
        d0 = done_cnt;
        cyc();
        cmd_valid = noise; m_ready = noise;
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < bub[i]; b++) begin
                s_valid = 1'b0; s_data = 8'($urandom);
                #1 chk("load_bubble_en", config_en, 0);
                chk("load_bubble_ctl", {s_ready, busy, cmd_ready, m_valid, done}, 5'b11000);
                cyc();
            end
            s_valid = 1'b1; s_data = w[i];
            #1 chk("load_beat_en", config_en, 1);
            chk("load_beat_in", config_in, w[i]);
            chk("load_beat_ctl", {s_ready, busy, cmd_ready, m_valid, done}, 5'b11000);
            cyc();
        end
        s_valid = noise;
        #1 chk("load_done", {done, busy, s_ready, config_en, cmd_ready}, 5'b11000);
        cyc();
        cmd_valid = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
        #1 chk("load_idle_after", {cmd_ready, busy, done}, 3'b100);
        chk("load_done_once", done_cnt - d0, 1);
        exp_q = {w0, w1};
        chk("load_tail", chain[1], exp_q[0]);
        chk("load_head", chain[0], exp_q[1]);
    endtask

    task automatic do_read(input int st0, input int st1);
        int         st [2];
        int         d0;
        logic [7:0] e;
        st[0] = st0; st[1] = st1;
        cmd_valid = 1'b1; cmd_readback = 1'b1;
        #1 chk("rd_cmd_ready", cmd_ready, 1);
        d0 = done_cnt;
        cyc();
        cmd_valid = 1'b0; cmd_readback = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            e = exp_q[i];
            for (int b = 0; b < st[i]; b++) begin
                m_ready = 1'b0; s_valid = 1'($urandom);
                #1 chk("rd_stall_data", m_data, e);
                chk("rd_stall_ctl", {m_valid, config_en, s_ready, busy, done}, 5'b10010);
                cyc();
            end
            m_ready = 1'b1; s_valid = 1'($urandom);
            #1 chk("rd_beat_data", m_data, e);
            chk("rd_beat_in", config_in, e);
            chk("rd_beat_ctl", {m_valid, config_en, s_ready, busy, done}, 5'b11010);
            cyc();
        end
        m_ready = 1'b0; s_valid = 1'b0;
        #1 chk("rd_done", {done, busy, m_valid, config_en}, 4'b1100);
        cyc();
        #1 chk("rd_idle_after", {cmd_ready, busy, done}, 3'b100);
        chk("rd_done_once", done_cnt - d0, 1);
        chk("rd_tail_kept", chain[1], exp_q[0]);
        chk("rd_head_kept", chain[0], exp_q[1]);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_readback = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        cmd_valid1 = 1'b0; cmd_readback1 = 1'b0; s_valid1 = 1'b0; s_data1 = 8'h00; m_ready1 = 1'b0;
        cyc();
        cyc();
        #1 chk("rst_outputs", {cmd_ready, s_ready, m_valid, config_en, busy, done, m_data, config_in}, 0);
        chk("rst_outputs_1", {cmd_ready1, s_ready1, m_valid1, config_en1, busy1, done1, m_data1, config_in1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_idle", {cmd_ready, busy, done}, 3'b100);
        chk("post_rst_idle_1", {cmd_ready1, busy1, done1}, 3'b100);

        do_load(8'hA5, 8'h3C, 0, 0, 1'b0);
        do_load(8'hA5, 8'h3C, 0, 2, 1'b0);
        do_read(3, 0);
        idle_noise();
        do_load(8'hC3, 8'h96, 1, 1, 1'b1);
        do_read(0, 0);

        // Abort a load after its first beat.
        cmd_valid = 1'b1; cmd_readback = 1'b0;
        cyc();
        cmd_valid = 1'b0; s_valid = 1'b1; s_data = 8'h77;
        cyc();
        begin
            int d0;
            d0 = done_cnt;
            rst_n = 1'b0; cmd_valid = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
            for (int k = 0; k < 3; k++) begin
                #1 chk("mid_rst_outputs",
                       {cmd_ready, s_ready, m_valid, config_en, busy, done, m_data, config_in}, 0);
                cyc();
            end
            rst_n = 1'b1; cmd_valid = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
            #1 chk("mid_rst_release", {cmd_ready, busy, done}, 3'b100);
            chk("mid_rst_no_done", done_cnt - d0, 0);
        end
        do_load(8'h11, 8'h22, 0, 0, 1'b0);
        do_read(0, 1);

        for (int it = 0; it < 6; it++) begin
            do_load(8'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
            do_read($urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Single-word chain: one beat per operation, done at T+2.
        cmd_valid1 = 1'b1; cmd_readback1 = 1'b0;
        #1 chk("w1_cmd_ready", cmd_ready1, 1);
        cyc();
        cmd_valid1 = 1'b0; s_valid1 = 1'b1; s_data1 = 8'h5A;
        #1 chk("w1_load_beat", {config_en1, s_ready1, config_in1}, {2'b11, 8'h5A});
        cyc();
        s_valid1 = 1'b0;
        #1 chk("w1_load_done", {done1, busy1, config_en1}, 3'b110);
        cyc();
        #1 chk("w1_load_idle", cmd_ready1, 1);
        chk("w1_load_chain", chain1, 8'h5A);
        cmd_valid1 = 1'b1; cmd_readback1 = 1'b1;
        cyc();
        cmd_valid1 = 1'b0; m_ready1 = 1'b1;
        #1 chk("w1_rd_beat", {m_valid1, config_en1, m_data1}, {2'b11, 8'h5A});
        cyc();
        m_ready1 = 1'b0;
        #1 chk("w1_rd_done", {done1, busy1, m_valid1}, 3'b110);
        cyc();
        #1 chk("w1_rd_idle", cmd_ready1, 1);
        chk("w1_rd_chain", chain1, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
